// File: rtl/wb_arbiter.sv
// Round-robin arbiter for COUNT pipelined Wishbone controllers sharing one bus.
// Ports: wb_clock_i/wb_reset_n_i clock and async active-low reset; wbc_cycle_i/wbc_strobe_i
// per-controller CYC/STB; wb_stall_i/wb_ack_i bus side; wbc_grant_o registered owner index;
// wbc_grant_valid_o admits new requests from the owner; busy_o is high while not IDLE.
// Ownership only moves once the owner's accepted-but-unacked requests have drained or it drops CYC.
module wb_arbiter #(
  parameter int COUNT           = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int QUANTUM         = 8
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_n_i,
  input  logic [COUNT-1:0]         wbc_cycle_i,
  input  logic [COUNT-1:0]         wbc_strobe_i,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i,
  output logic [$clog2(COUNT)-1:0] wbc_grant_o,
  output logic                     wbc_grant_valid_o,
  output logic                     busy_o
);

  localparam int GW = $clog2(COUNT);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // A zero quantum never preempts; keep a 1-bit counter so widths stay legal.
  localparam int BW = (QUANTUM > 0) ? $clog2(QUANTUM + 1) : 1;
  localparam bit QEN = (QUANTUM != 0);
  localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(QUANTUM);
  localparam logic [GW-1:0] GRANT_RST = GW'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [GW-1:0]   rr_pick;
  logic [OW-1:0]   out_cnt, out_nxt;
  logic [BW-1:0]   beat_cnt, beat_nxt;
  logic [COUNT-1:0] others_mask;
  logic            others;
  logic            own_cyc;
  logic            quantum_hit;
  logic            accept;
  logic            ack_dec;

  // Requesters other than the current owner.
  always_comb begin
    others_mask              = wbc_cycle_i;
    others_mask[wbc_grant_o] = 1'b0;
  end

  assign others  = |others_mask;
  assign own_cyc = wbc_cycle_i[wbc_grant_o];

  // Quantum used up while someone else waits: stop admitting so the bus can drain.
  assign quantum_hit = QEN && (beat_cnt == BEAT_MAX) && others;

  assign wbc_grant_valid_o = (state == GRANTED) && (out_cnt < OUT_MAX) && !quantum_hit;
  assign accept  = wbc_grant_valid_o && wbc_strobe_i[wbc_grant_o] && !wb_stall_i;
  // Spurious acks with nothing outstanding are dropped rather than underflowing.
  assign ack_dec = wb_ack_i && (out_cnt != '0);
  assign busy_o  = (state != IDLE);

  // Round-robin scan starting just after the current owner; the loop runs from the
  // farthest offset down so the nearest requester is the last (winning) assignment.
  always_comb begin
    rr_pick = wbc_grant_o;
    for (int i = COUNT; i >= 1; i--) begin
      if (wbc_cycle_i[(int'(wbc_grant_o) + i) % COUNT]) begin
        rr_pick = GW'((int'(wbc_grant_o) + i) % COUNT);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = wbc_grant_o;
    out_nxt   = out_cnt;
    beat_nxt  = beat_cnt;
    unique case (state)
      IDLE: begin
        if (|wbc_cycle_i) begin
          state_nxt = GRANTED;
          grant_nxt = rr_pick;
          out_nxt   = '0;
          beat_nxt  = '0;
        end
      end
      GRANTED: begin
        out_nxt = out_cnt + OW'(accept) - OW'(ack_dec);
        if (accept && (beat_cnt != BEAT_MAX)) begin
          beat_nxt = beat_cnt + BW'(1);
        end
        if (!own_cyc) begin
          // Owner aborted: outstanding acks are forgotten.
          state_nxt = IDLE;
          out_nxt   = '0;
          beat_nxt  = '0;
        end else if (QEN && (beat_nxt == BEAT_MAX) && others) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_nxt = out_cnt - OW'(ack_dec);
        if ((out_nxt == '0) || !own_cyc) begin
          state_nxt = IDLE;
          out_nxt   = '0;
          beat_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        out_nxt   = '0;
        beat_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
    if (!wb_reset_n_i) begin
      state       <= IDLE;
      wbc_grant_o <= GRANT_RST;
      out_cnt     <= '0;
      beat_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      wbc_grant_o <= grant_nxt;
      out_cnt     <= out_nxt;
      beat_cnt    <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed vector table, multi-cycle corner sequences,
// a three-controller instance, and randomized traffic against a reference model.
module tb_wb_arbiter;

  localparam int NC   = 2;
  localparam int MAXO = 4;
  localparam int QN   = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] cyc, stb;
  logic       stall, ack;
  logic       grant;
  logic       valid, busy;

  logic [2:0] c3_cyc, c3_stb;
  logic       c3_stall, c3_ack;
  logic [1:0] c3_grant;
  logic       c3_valid, c3_busy;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.COUNT(NC), .MAX_OUTSTANDING(MAXO), .QUANTUM(QN)) dut (
    .wb_clock_i(clk), .wb_reset_n_i(rst_n),
    .wbc_cycle_i(cyc), .wbc_strobe_i(stb),
    .wb_stall_i(stall), .wb_ack_i(ack),
    .wbc_grant_o(grant), .wbc_grant_valid_o(valid), .busy_o(busy)
  );

  wb_arbiter #(.COUNT(3), .MAX_OUTSTANDING(MAXO), .QUANTUM(QN)) dut3 (
    .wb_clock_i(clk), .wb_reset_n_i(rst_n),
    .wbc_cycle_i(c3_cyc), .wbc_strobe_i(c3_stb),
    .wb_stall_i(c3_stall), .wb_ack_i(c3_ack),
    .wbc_grant_o(c3_grant), .wbc_grant_valid_o(c3_valid), .busy_o(c3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       stall;
    logic       ack;
    logic       g;
    logic       v;
    logic       b;
  } vec_t;

  vec_t vecs[21];

  // scratch for sequences and the reference model
  int n, bad, epoch, drain_vld;
  int accs[8];
  int epoch_g[8];
  logic cur_g, prev_acc;
  int m_state, m_g, m_out, m_beat, pick, found;
  logic oth, exp_v, acc;

  initial begin
    rst_n = 1'b0; cyc = '0; stb = '0; stall = 1'b0; ack = 1'b0;
    c3_cyc = '0; c3_stb = '0; c3_stall = 1'b0; c3_ack = 1'b0;

    //               cyc    stb    stl ack  g  v  b
    vecs[0]  = '{2'b00, 2'b00, 0, 0, 1, 0, 0};
    vecs[1]  = '{2'b00, 2'b00, 0, 0, 1, 0, 0};
    vecs[2]  = '{2'b01, 2'b00, 0, 0, 1, 0, 0};
    vecs[3]  = '{2'b01, 2'b01, 0, 0, 0, 1, 1};
    vecs[4]  = '{2'b01, 2'b01, 0, 0, 0, 1, 1};
    vecs[5]  = '{2'b01, 2'b01, 0, 0, 0, 1, 1};
    vecs[6]  = '{2'b01, 2'b01, 0, 0, 0, 1, 1};
    vecs[7]  = '{2'b01, 2'b01, 0, 0, 0, 0, 1};
    vecs[8]  = '{2'b01, 2'b01, 0, 1, 0, 0, 1};
    vecs[9]  = '{2'b01, 2'b01, 0, 1, 0, 1, 1};
    vecs[10] = '{2'b01, 2'b01, 0, 0, 0, 1, 1};
    vecs[11] = '{2'b01, 2'b01, 0, 0, 0, 0, 1};
    vecs[12] = '{2'b01, 2'b00, 0, 1, 0, 0, 1};
    vecs[13] = '{2'b01, 2'b00, 0, 1, 0, 1, 1};
    vecs[14] = '{2'b00, 2'b00, 0, 0, 0, 1, 1};
    vecs[15] = '{2'b00, 2'b00, 0, 1, 0, 0, 0};
    vecs[16] = '{2'b11, 2'b00, 0, 0, 0, 0, 0};
    vecs[17] = '{2'b11, 2'b00, 0, 0, 1, 1, 1};
    vecs[18] = '{2'b11, 2'b10, 0, 0, 1, 1, 1};
    vecs[19] = '{2'b00, 2'b00, 0, 0, 1, 1, 1};
    vecs[20] = '{2'b00, 2'b00, 0, 0, 1, 0, 0};

    // ---- reset state
    @(negedge clk); #1;
    check("rst_grant", grant, 1);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst3_grant", c3_grant, 2);
    @(negedge clk); rst_n = 1'b1;

    // ---- directed vector table
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      cyc = vecs[i].cyc; stb = vecs[i].stb; stall = vecs[i].stall; ack = vecs[i].ack;
      #1;
      check($sformatf("vec%0d_grant", i), grant, vecs[i].g);
      check($sformatf("vec%0d_valid", i), valid, vecs[i].v);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].b);
    end

    // ---- asynchronous reset in the middle of a grant
    @(negedge clk); cyc = 2'b01; stb = 2'b01; ack = 1'b0; #1;
    @(negedge clk); #1;
    check("midrst_pre_grant", grant, 0);
    check("midrst_pre_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_grant", grant, 1);
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk); cyc = 2'b00; stb = 2'b00; rst_n = 1'b1;

    // ---- quantum sharing: both controllers busy, single-cycle acks
    cur_g = 1'b1; prev_acc = 1'b0; epoch = 0; drain_vld = 0;
    for (int i = 0; i < 8; i++) begin accs[i] = 0; epoch_g[i] = -1; end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cyc = 2'b11; stb = 2'b11; stall = 1'b0; ack = prev_acc;
      #1;
      if (grant !== cur_g && epoch < 7) begin
        epoch++;
        cur_g = grant;
        epoch_g[epoch] = int'(grant);
      end
      prev_acc = valid && stb[grant] && !stall;
      if (prev_acc) accs[epoch]++;
      else if (valid && accs[epoch] >= QN) drain_vld++;
    end
    check("q_first_owner", epoch_g[1], 0);
    check("q_first_accepts", accs[1], QN);
    check("q_second_owner", epoch_g[2], 1);
    check("q_second_accepts", accs[2], QN);
    check("q_third_owner", epoch_g[3], 0);
    check("q_valid_in_drain", drain_vld, 0);
    @(negedge clk); cyc = 2'b00; stb = 2'b00; ack = 1'b0;
    @(negedge clk);

    // ---- lone controller 1: quantum never preempts
    @(negedge clk); cyc = 2'b10; stb = 2'b10; ack = 1'b0; #1;
    n = 0;
    while (!valid && n < 5) begin @(negedge clk); ack = 1'b0; #1; n++; end
    check("solo_valid_up", valid, 1);
    bad = 0; prev_acc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) begin @(negedge clk); ack = prev_acc; #1; end
      if (!(valid === 1'b1 && grant === 1'b1)) bad++;
      prev_acc = valid;
    end
    check("solo_20_accepts", bad, 0);
    // beat count saturated at the quantum: a newcomer blocks admission at once
    @(negedge clk); cyc = 2'b11; ack = prev_acc; #1;
    check("solo_sat_valid", valid, 0);
    check("solo_sat_grant", grant, 1);
    n = 0;
    while (grant !== 1'b0 && n < 6) begin @(negedge clk); ack = 1'b0; #1; n++; end
    check("solo_handover", grant, 0);
    @(negedge clk); cyc = 2'b00; stb = 2'b00; ack = 1'b0;
    @(negedge clk);

    // ---- three controllers: round-robin skip and stalled grant
    @(negedge clk); c3_cyc = 3'b101; #1;
    check("c3_idle_grant", c3_grant, 2);
    @(negedge clk); #1;
    check("c3_first_grant", c3_grant, 0);
    check("c3_first_valid", c3_valid, 1);
    @(negedge clk); c3_cyc = 3'b000; #1;
    @(negedge clk); c3_cyc = 3'b101; #1;
    check("c3_idle_busy", c3_busy, 0);
    @(negedge clk); c3_stb = 3'b100; c3_stall = 1'b1; #1;
    check("c3_skip_grant", c3_grant, 2);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (!(c3_valid === 1'b1 && c3_grant === 2'd2)) bad++;
    end
    check("c3_stall_hold", bad, 0);
    @(negedge clk); c3_cyc = '0; c3_stb = '0; c3_stall = 1'b0;

    // ---- randomized traffic against the reference model
    @(negedge clk); rst_n = 1'b0; cyc = '0; stb = '0; stall = 1'b0; ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_state = 0; m_g = NC - 1; m_out = 0; m_beat = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) if ($urandom_range(0, 15) == 0) cyc[i] = ~cyc[i];
      stb   = 2'($urandom_range(0, 3));
      stall = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 9) < 4);
      #1;
      oth = 1'b0;
      for (int i = 0; i < NC; i++) if (i != m_g && cyc[i]) oth = 1'b1;
      exp_v = (m_state == 1) && (m_out < MAXO) && !(QN != 0 && m_beat == QN && oth);
      check($sformatf("rand%0d_gvb", c), {grant, valid, busy}, {m_g[0], exp_v, (m_state != 0)});
      // reference next state
      if (m_state == 0) begin
        if (cyc != 0) begin
          found = 0; pick = m_g;
          for (int k = 1; k <= NC; k++) begin
            if (found == 0 && cyc[(m_g + k) % NC]) begin found = 1; pick = (m_g + k) % NC; end
          end
          m_g = pick; m_state = 1; m_out = 0; m_beat = 0;
        end
      end else if (m_state == 1) begin
        acc = exp_v && stb[m_g] && !stall;
        if (ack && m_out > 0) m_out--;
        if (acc) m_out++;
        if (acc && m_beat < QN) m_beat++;
        if (!cyc[m_g]) begin m_state = 0; m_out = 0; m_beat = 0; end
        else if (QN != 0 && m_beat == QN && oth) m_state = 2;
      end else begin
        if (ack && m_out > 0) m_out--;
        if (m_out == 0 || !cyc[m_g]) begin m_state = 0; m_out = 0; m_beat = 0; end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin arbiter for COUNT Wishbone controllers sharing one pipelined bus.
- Drives wbc_grant_o and wbc_grant_valid_o into the downstream controller demux.
- Tracks outstanding (accepted, un-acked) requests so ownership changes only when the bus is quiescent.
- Bounds each grant's accepted requests to QUANTUM when other controllers are waiting, and caps in-flight requests at MAX_OUTSTANDING.

Parameters:
COUNT, 2, number of controllers (>=2)
MAX_OUTSTANDING, 4, max accepted-but-unacked requests for the granted controller (>=1)
QUANTUM, 8, accepted requests per grant before yielding to waiting controllers; 0 = never preempt

Ports:
wb_clock_i  input  1  clock
wb_reset_n_i  input  1  asynchronous active-low reset
wbc_cycle_i  input  COUNT  per-controller CYC
wbc_strobe_i  input  COUNT  per-controller STB
wb_stall_i  input  1  bus STALL (peripheral side)
wb_ack_i  input  1  bus ACK (peripheral side)
wbc_grant_o  output  $clog2(COUNT)  selected controller index (registered)
wbc_grant_valid_o  output  1  1 = admit new requests from the granted controller (combinational from state/counters)
busy_o  output  1  state != IDLE (registered-state decode)

Behaviour:
- Definitions:
  - g = wbc_grant_o.
  - accept = wbc_grant_valid_o & wbc_strobe_i[g] & !wb_stall_i.
  - others = |(wbc_cycle_i with bit g masked).
  - out_cnt width $clog2(MAX_OUTSTANDING+1); beat_cnt width $clog2(QUANTUM+1), saturates at QUANTUM.
- Reset (async, wb_reset_n_i=0):
  - state=IDLE, wbc_grant_o=COUNT-1 (so controller 0 wins first), out_cnt=0, beat_cnt=0.
  - wbc_grant_valid_o=0, busy_o=0.
- wbc_grant_valid_o = (state==GRANTED) & (out_cnt < MAX_OUTSTANDING) & !(QUANTUM!=0 & beat_cnt==QUANTUM & others).
- IDLE:
  - If any wbc_cycle_i is set, select the first requester scanning g+1, g+2, ... modulo COUNT (g itself is last priority).
  - Register its index into wbc_grant_o; out_cnt=0, beat_cnt=0; go to GRANTED.
  - Latency: CYC asserted in cycle N -> grant_o updated and valid=1 in cycle N+1.
  - Acks seen in IDLE are ignored.
- GRANTED:
  - out_cnt += accept - (wb_ack_i & out_cnt!=0). Simultaneous accept+ack leaves it unchanged; no underflow.
  - beat_cnt += accept (saturating).
  - If wbc_cycle_i[g]==0: go to IDLE, clear counters. Dropping CYC aborts the transaction; pending acks are discarded. wbc_grant_o holds its value.
  - Else if QUANTUM!=0 & beat_cnt (next value) == QUANTUM & others: go to DRAIN.
  - Reaching MAX_OUTSTANDING only deasserts valid; state is unchanged.
- DRAIN:
  - valid=0; out_cnt decrements on ack.
  - Go to IDLE when out_cnt reaches 0 (an ack bringing it to 0 counts) or wbc_cycle_i[g]==0.
  - In IDLE the round-robin scan naturally favours the other controllers.
- If only the granted controller requests, the quantum never preempts: valid stays asserted and beat_cnt stays saturated.
- Mid-operation reset: all state clears immediately; any bus transaction in progress is abandoned.
- wbc_grant_o never changes outside the IDLE->GRANTED transition.

Test Plan:
- Reset, then cycle_i=2'b01 in cycle 3 -> cycle 4: grant_o=0, valid=1, busy_o=1; reset asserted mid-GRANTED -> grant_o=1, valid=0, busy_o=0 asynchronously.
- Controller 0 issues 4 strobes, stall=0, no acks (MAX_OUTSTANDING=4) -> valid drops after the 4th accept; one ack -> valid=1 next cycle; accept+ack in the same cycle -> out_cnt stays 3.
- Both cycle_i bits held high, QUANTUM=8, single-cycle acks -> controller 0 gets exactly 8 accepts, valid low during DRAIN until the 8th ack, then grant_o=1; then 8 accepts for controller 1, back to 0.
- Only controller 1 requests, 20 accepts -> no DRAIN; valid stays 1 for all 20, beat_cnt saturated at 8.
- Controller 0 drops CYC with out_cnt=2 -> next cycle state=IDLE, counters 0; a late ack in IDLE is ignored, and with cycle_i=2'b11 the grant goes to 1.
- COUNT=3, requesters {0,2}, last grant 0 -> next grant 2; wb_stall_i=1 throughout GRANTED -> out_cnt and beat_cnt stay 0 while valid=1.
